occupancy_display: RTL and testbench

//  Downstream stage of the parking-lot counter. Consumes occupancy count plus the
//  one-cycle entry/exit pulses of the in/out FSMs; drives a 4-digit multiplexed

---
 rtl/parking_pkg.sv | 54 +++++
 rtl/tick_gen.sv | 28 ++
 rtl/occupancy_display.sv | 174 +++++++++++++++++
 tb/tb_occupancy_display.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot display path:
// FSM state encoding, 7-segment glyphs (active-low {g,f,e,d,c,b,a}) and status text.
package parking_pkg;

  localparam int unsigned CAPACITY_DEFAULT = 7;
  localparam int unsigned SEG_W            = 7;
  localparam int unsigned DIGITS           = 4;
  localparam int unsigned DIG_W            = $clog2(DIGITS);
  localparam int unsigned COUNT_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW_IN  = 2'd1,
    ST_SHOW_OUT = 2'd2,
    ST_FULL     = 2'd3
  } state_e;

  typedef logic [SEG_W-1:0] glyph_t;

  // Status text shown on digits 3..1, leftmost character first.
  typedef struct packed {
    glyph_t d3;
    glyph_t d2;
    glyph_t d1;
  } text_t;

  localparam glyph_t GLYPH_0     = 7'b1000000;
  localparam glyph_t GLYPH_1     = 7'b1111001;
  localparam glyph_t GLYPH_2     = 7'b0100100;
  localparam glyph_t GLYPH_3     = 7'b0110000;
  localparam glyph_t GLYPH_4     = 7'b0011001;
  localparam glyph_t GLYPH_5     = 7'b0010010;
  localparam glyph_t GLYPH_6     = 7'b0000010;
  localparam glyph_t GLYPH_7     = 7'b1111000;
  localparam glyph_t GLYPH_BLANK = 7'b1111111;
  localparam glyph_t GLYPH_DASH  = 7'b0111111;
  localparam glyph_t GLYPH_I     = 7'b1111001;
  localparam glyph_t GLYPH_N_LC  = 7'b0101011;
  localparam glyph_t GLYPH_O     = 7'b1000000;
  localparam glyph_t GLYPH_U_LC  = 7'b1100011;
  localparam glyph_t GLYPH_T_LC  = 7'b0000111;
  localparam glyph_t GLYPH_F     = 7'b0001110;
  localparam glyph_t GLYPH_U     = 7'b1000001;
  localparam glyph_t GLYPH_L     = 7'b1000111;
  localparam glyph_t GLYPH_E     = 7'b0000110;
  localparam glyph_t GLYPH_R_LC  = 7'b0101111;

  localparam text_t TEXT_IDLE = '{d3: GLYPH_DASH, d2: GLYPH_DASH, d1: GLYPH_DASH};
  localparam text_t TEXT_IN   = '{d3: GLYPH_I,    d2: GLYPH_N_LC, d1: GLYPH_BLANK};
  localparam text_t TEXT_OUT  = '{d3: GLYPH_O,    d2: GLYPH_U_LC, d1: GLYPH_T_LC};
  localparam text_t TEXT_FULL = '{d3: GLYPH_F,    d2: GLYPH_U,    d1: GLYPH_L};
  localparam text_t TEXT_ERR  = '{d3: GLYPH_E,    d2: GLYPH_R_LC, d1: GLYPH_R_LC};

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..DIV-1 counter with a terminal-count pulse and synchronous clear.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == LAST) && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/occupancy_display.sv
// Multiplexed 4-digit status display for the parking-lot counter: status text on
// digits 3..1, occupancy on digit 0, transient In/Out messages and a blinking FULL.
module occupancy_display
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY   = CAPACITY_DEFAULT,
  parameter int unsigned SCAN_DIV   = 50_000,
  parameter int unsigned EVENT_HOLD = 100_000_000,
  parameter int unsigned BLINK_DIV  = 12_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count,
  input  logic               car_in,
  input  logic               car_out,
  output logic [SEG_W-1:0]   seg,
  output logic [DIGITS-1:0]  an,
  output logic               full
);

  localparam int unsigned HOLD_W = $clog2(EVENT_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(EVENT_HOLD - 1);
  localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);

  state_e              state;
  state_e              state_next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_next;
  logic [DIG_W-1:0]    digit_idx;
  logic                scan_tick_c;
  logic                blink_tick_c;
  logic                blink_phase;
  logic                at_cap_c;
  logic                over_cap_c;
  text_t               text_c;
  glyph_t              digit0_c;
  glyph_t              seg_next_c;
  logic [DIGITS-1:0]   an_next_c;

  assign at_cap_c   = (count >= CAP);
  assign over_cap_c = (count > CAP);

  function automatic glyph_t count_glyph(input logic [COUNT_W-1:0] v);
    case (v)
      3'd0:    return GLYPH_0;
      3'd1:    return GLYPH_1;
      3'd2:    return GLYPH_2;
      3'd3:    return GLYPH_3;
      3'd4:    return GLYPH_4;
      3'd5:    return GLYPH_5;
      3'd6:    return GLYPH_6;
      default: return GLYPH_7;
    endcase
  endfunction

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (1'b0),
    .tick_c (scan_tick_c)
  );

  // Blink timer only runs in FULL, so every entry to FULL starts in the visible phase.
  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_FULL),
    .tick_c (blink_tick_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  // Events pre-empt everything; entry wins when both pulses coincide.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    if (car_in) begin
      state_next = ST_SHOW_IN;
      hold_next  = HOLD_LOAD;
    end else if (car_out) begin
      state_next = ST_SHOW_OUT;
      hold_next  = HOLD_LOAD;
    end else begin
      case (state)
        ST_SHOW_IN, ST_SHOW_OUT: begin
          if (hold_cnt == '0) begin
            state_next = at_cap_c ? ST_FULL : ST_IDLE;
          end else begin
            hold_next = hold_cnt - HOLD_W'(1);
          end
        end
        ST_IDLE: begin
          if (at_cap_c) state_next = ST_FULL;
        end
        ST_FULL: begin
          if (!at_cap_c) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state != ST_FULL)) begin
      blink_phase <= 1'b0;
    end else if (blink_tick_c) begin
      blink_phase <= ~blink_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_idx <= '0;
    end else if (scan_tick_c) begin
      digit_idx <= digit_idx + DIG_W'(1);
    end
  end

  always_comb begin
    text_c = TEXT_IDLE;
    if (over_cap_c) begin
      text_c = TEXT_ERR;
    end else begin
      case (state)
        ST_SHOW_IN:  text_c = TEXT_IN;
        ST_SHOW_OUT: text_c = TEXT_OUT;
        ST_FULL:     text_c = TEXT_FULL;
        default:     text_c = TEXT_IDLE;
      endcase
    end
  end

  always_comb begin
    digit0_c = count_glyph(count);
    if (over_cap_c) begin
      digit0_c = GLYPH_E;
    end else if ((state == ST_FULL) && blink_phase) begin
      digit0_c = GLYPH_BLANK;
    end
  end

  // an and seg derive from the same digit index so they switch together.
  always_comb begin
    an_next_c  = ~(DIGITS'(1) << digit_idx);
    seg_next_c = digit0_c;
    case (digit_idx)
      2'd1:    seg_next_c = text_c.d1;
      2'd2:    seg_next_c = text_c.d2;
      2'd3:    seg_next_c = text_c.d3;
      default: seg_next_c = digit0_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an   <= '1;
      seg  <= GLYPH_BLANK;
      full <= 1'b0;
    end else begin
      an   <= an_next_c;
      seg  <= seg_next_c;
      full <= at_cap_c;
    end
  end

endmodule

// File: tb/tb_occupancy_display.sv
// Directed bench for occupancy_display with short timers (scan 4, hold 20, blink 8).
module tb_occupancy_display;

  localparam logic [6:0] G0    = 7'b1000000;
  localparam logic [6:0] G2    = 7'b0100100;
  localparam logic [6:0] G3    = 7'b0110000;
  localparam logic [6:0] G6    = 7'b0000010;
  localparam logic [6:0] G7    = 7'b1111000;
  localparam logic [6:0] GBL   = 7'b1111111;
  localparam logic [6:0] GDASH = 7'b0111111;
  localparam logic [6:0] GI    = 7'b1111001;
  localparam logic [6:0] GN    = 7'b0101011;
  localparam logic [6:0] GO    = 7'b1000000;
  localparam logic [6:0] GUL   = 7'b1100011;
  localparam logic [6:0] GT    = 7'b0000111;
  localparam logic [6:0] GF    = 7'b0001110;
  localparam logic [6:0] GU    = 7'b1000001;
  localparam logic [6:0] GL    = 7'b1000111;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       car_in;
  logic       car_out;
  logic [6:0] seg;
  logic [3:0] an;
  logic       full;

  int total;
  int bad;

  occupancy_display #(
    .CAPACITY   (7),
    .SCAN_DIV   (4),
    .EVENT_HOLD (20),
    .BLINK_DIV  (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .car_in  (car_in),
    .car_out (car_out),
    .seg     (seg),
    .an      (an),
    .full    (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected glyph for whichever digit is enabled; unknown for an invalid enable pattern.
  function automatic logic [6:0] pick(input logic [3:0] a, input logic [6:0] g3,
                                      input logic [6:0] g2, input logic [6:0] g1,
                                      input logic [6:0] g0);
    case (a)
      4'b1110: pick = g0;
      4'b1101: pick = g1;
      4'b1011: pick = g2;
      4'b0111: pick = g3;
      default: pick = 7'bxxxxxxx;
    endcase
  endfunction

  task automatic test_reset();
    logic [3:0] ea;
    logic [6:0] es;
    reset = 1'b1; count = 3'd0; car_in = 1'b0; car_out = 1'b0;
    repeat (3) tick();
    total++;
    if (an !== 4'b1111) begin bad++; $display("FAIL reset_an: got %b want 1111", an); end
    total++;
    if (seg !== GBL) begin bad++; $display("FAIL reset_seg: got %b want %b", seg, GBL); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    reset = 1'b0;
    tick();
    total++;
    if (an !== 4'b1110 || seg !== G0) begin
      bad++; $display("FAIL first_after_reset: got an=%b seg=%b want an=1110 seg=%b", an, seg, G0);
    end
    for (int k = 1; k < 16; k++) begin
      tick();
      ea = ~(4'b0001 << (k / 4));
      es = pick(ea, GDASH, GDASH, GDASH, G0);
      total++;
      if (an !== ea || seg !== es) begin
        bad++; $display("FAIL scan_idle k=%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, ea, es);
      end
    end
  endtask

  task automatic test_car_in();
    logic [6:0] es;
    count = 3'd3; car_in = 1'b1;
    tick();
    car_in = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      es = (k <= 20) ? pick(an, GI, GN, GBL, G3) : pick(an, GDASH, GDASH, GDASH, G3);
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL car_in_text k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
  endtask

  task automatic test_car_out();
    logic [6:0] es;
    count = 3'd3; car_in = 1'b1;
    tick();
    car_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      es = pick(an, GI, GN, GBL, G3);
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL pre_out_in k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
    count = 3'd2; car_out = 1'b1;
    tick();
    car_out = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      tick();
      es = (k <= 20) ? pick(an, GO, GUL, GT, G2) : pick(an, GDASH, GDASH, GDASH, G2);
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL car_out_text k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] es;
    count = 3'd2; car_out = 1'b1;
    tick();
    car_out = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      es = pick(an, GO, GUL, GT, G2);
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL b2b_out k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
    count = 3'd3; car_in = 1'b1; car_out = 1'b1;
    tick();
    car_in = 1'b0; car_out = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      es = (k <= 20) ? pick(an, GI, GN, GBL, G3) : pick(an, GDASH, GDASH, GDASH, G3);
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL b2b_in k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
  endtask

  task automatic test_full();
    logic [6:0] es;
    logic [6:0] d0;
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL full_before: got %b want 0", full); end
    count = 3'd7; car_in = 1'b1;
    tick();
    car_in = 1'b0;
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", full); end
    for (int k = 1; k <= 52; k++) begin
      tick();
      if (k <= 20) begin
        es = pick(an, GI, GN, GBL, G7);
      end else begin
        d0 = (((k - 21) / 8) % 2 == 1) ? GBL : G7;
        es = pick(an, GF, GU, GL, d0);
      end
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL full_text k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
    count = 3'd6; car_out = 1'b1;
    tick();
    car_out = 1'b0;
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL full_clear: got %b want 0", full); end
    for (int k = 1; k <= 22; k++) begin
      tick();
      es = (k <= 20) ? pick(an, GO, GUL, GT, G6) : pick(an, GDASH, GDASH, GDASH, G6);
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL leave_full k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
  endtask

  task automatic test_reset_mid_message();
    logic [3:0] ea;
    logic [6:0] es;
    count = 3'd2; car_out = 1'b1;
    tick();
    car_out = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      es = pick(an, GO, GUL, GT, G2);
      total++;
      if (seg !== es) begin
        bad++; $display("FAIL mid_out k=%0d an=%b: got %b want %b", k, an, seg, es);
      end
    end
    reset = 1'b1;
    tick();
    total++;
    if (an !== 4'b1111 || seg !== GBL || full !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got an=%b seg=%b full=%b want an=1111 seg=%b full=0", an, seg, full, GBL);
    end
    reset = 1'b0;
    tick();
    total++;
    if (an !== 4'b1110 || seg !== G2) begin
      bad++; $display("FAIL mid_release: got an=%b seg=%b want an=1110 seg=%b", an, seg, G2);
    end
    for (int k = 1; k < 16; k++) begin
      tick();
      ea = ~(4'b0001 << (k / 4));
      es = pick(ea, GDASH, GDASH, GDASH, G2);
      total++;
      if (an !== ea || seg !== es) begin
        bad++; $display("FAIL post_reset_idle k=%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, ea, es);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; count = 3'd0; car_in = 1'b0; car_out = 1'b0;
    test_reset();
    test_car_in();
    test_car_out();
    test_back_to_back();
    test_full();
    test_reset_mid_message();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
